// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: request/response front-end and sole master of a single-port synchronous RAM.
// Turns a valid/ready request stream (read or write) into RAM port cycles. It captures the
// RAM's registered read data and returns read responses in order through a 2-entry buffer
// with valid/ready backpressure. Writes produce no response.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset (also drives the RAM's reset)
//   req_valid_i       request present
//   req_ready_o       request can be accepted this cycle
//   req_we_i          1 = write, 0 = read
//   req_addr_i        request address
//   req_wdata_i       write data (ignored for reads)
//   rsp_valid_o       read response present
//   rsp_ready_i       consumer accepts the response
//   rsp_rdata_o       read response data (head of the response buffer)
//   ram_wr_en_o       RAM write enable
//   ram_addr_o        RAM address
//   ram_wr_data_o     RAM write data
//   ram_rd_data_i     RAM read data, registered in the RAM, valid one cycle after the address
module ram_req_ctrl #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_i
);

  logic                  accept;
  logic                  pop;
  logic                  push;
  logic [1:0]            credit_used;

  logic                  rd_pend_q, rd_pend_d;
  logic [1:0]            count_q, count_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] buf_q [2];

  always_comb begin
    rsp_valid_o = (count_q != 2'd0);
    rsp_rdata_o = buf_q[rd_ptr_q];
    pop         = rsp_valid_o && rsp_ready_i;
    push        = rd_pend_q;

    // Buffered entries plus the read in flight, less the slot freed this cycle.
    // count_q + rd_pend_q never exceeds 2 and pop implies count_q >= 1, so 2 bits suffice.
    credit_used = count_q + {1'b0, rd_pend_q} - {1'b0, pop};
    req_ready_o = rst_n && (credit_used < 2'd2);
    accept      = req_valid_i && req_ready_o;

    ram_addr_o    = req_addr_i;
    ram_wr_data_o = req_wdata_i;
    ram_wr_en_o   = accept && req_we_i;

    rd_pend_d = accept && !req_we_i;
    count_d   = count_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pend_q <= 1'b0;
      count_q   <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
    end else begin
      rd_pend_q <= rd_pend_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only visible once count_q covers it.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      buf_q[wr_ptr_q] <= ram_rd_data_i;
    end
  end

endmodule
